// File: rtl/pixel_reader_if.sv
// Bus bundle between the frame-buffer read engine and its surroundings.
//   frameReady  : write side has handed the SRAM over (level, already synchronized)
//   sramAddr    : SRAM read address
//   sramRdEn    : SRAM read strobe, data returns on sramRdData one cycle later
//   sramRdData  : SRAM read data word
//   readData    : byte presented to the transmitter
//   txStart     : one-cycle pulse, readData valid in that cycle
//   txStatus    : transmitter busy (1) / idle (0)
//   readDone    : frame fully sent (level), returned to the write side
// master = the read engine, slave = SRAM/transmitter/write-side environment.
interface pixel_reader_if #(
  parameter int ADDR_W = 15
);
  logic              frameReady;
  logic [ADDR_W-1:0] sramAddr;
  logic              sramRdEn;
  logic [15:0]       sramRdData;
  logic [7:0]        readData;
  logic              txStart;
  logic              txStatus;
  logic              readDone;

  modport master (
    input  frameReady, sramRdData, txStatus,
    output sramAddr, sramRdEn, readData, txStart, readDone
  );

  modport slave (
    output frameReady, sramRdData, txStatus,
    input  sramAddr, sramRdEn, readData, txStart, readDone
  );
endinterface

// File: rtl/pixel_reader.sv
// Read-side engine for the camera frame buffer.
// Walks every word of the frame, splits each 16-bit word into two bytes
// (low byte first) and feeds them one at a time to the byte-serial
// transmitter using the txStart/txStatus handshake. Optionally prefixes
// each frame with the sync bytes AA, 55. When the last byte has been
// accepted, readDone is raised and held until frameReady drops.
// Ports:
//   readClk : clock, all logic on the rising edge
//   readRst : asynchronous, active-high reset
//   bus     : pixel_reader_if master modport (SRAM, transmitter, handover)
module pixel_reader #(
  parameter int WORDS     = 19200,
  parameter int ADDR_W    = 15,
  parameter bit HEADER_EN = 1'b1
) (
  input  logic           readClk,
  input  logic           readRst,
  pixel_reader_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, FETCH, LATCH, SEND, WAIT_BUSY, WAIT_IDLE, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [7:0]        SYNC0     = 8'hAA;
  localparam logic [7:0]        SYNC1     = 8'h55;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wordBuf;
  logic              byteSel;   // 0: low byte pending, 1: high byte pending
  logic              inHdr;     // the byte in flight is a sync byte
  logic              hdrSel;    // which sync byte is in flight
  logic              rdEn;
  logic [7:0]        txByte;
  logic              txPulse;
  logic              done;
  logic              abort;

  assign bus.sramAddr = addr;
  assign bus.sramRdEn = rdEn;
  assign bus.readData = txByte;
  assign bus.txStart  = txPulse;
  assign bus.readDone = done;

  // Losing the SRAM mid-frame abandons the frame; IDLE and DONE handle
  // frameReady low themselves.
  assign abort = !bus.frameReady && (state != IDLE) && (state != DONE);

  function automatic logic [7:0] pickByte(input logic [15:0] w, input logic sel);
    return sel ? w[15:8] : w[7:0];
  endfunction

  always_ff @(posedge readClk or posedge readRst) begin
    if (readRst) begin
      state   <= IDLE;
      addr    <= '0;
      wordBuf <= '0;
      byteSel <= 1'b0;
      inHdr   <= 1'b0;
      hdrSel  <= 1'b0;
      rdEn    <= 1'b0;
      txByte  <= 8'h00;
      txPulse <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      rdEn    <= 1'b0;
      txPulse <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        addr    <= '0;
        byteSel <= 1'b0;
        inHdr   <= 1'b0;
        hdrSel  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            addr    <= '0;
            byteSel <= 1'b0;
            inHdr   <= 1'b0;
            hdrSel  <= 1'b0;
            if (bus.frameReady && !bus.txStatus) begin
              if (HEADER_EN) begin
                state <= HDR0;
              end else begin
                state <= FETCH;
                rdEn  <= 1'b1;
              end
            end
          end
          HDR0: begin
            if (!bus.txStatus) begin
              txByte  <= SYNC0;
              txPulse <= 1'b1;
              inHdr   <= 1'b1;
              hdrSel  <= 1'b0;
              state   <= WAIT_BUSY;
            end
          end
          HDR1: begin
            if (!bus.txStatus) begin
              txByte  <= SYNC1;
              txPulse <= 1'b1;
              inHdr   <= 1'b1;
              hdrSel  <= 1'b1;
              state   <= WAIT_BUSY;
            end
          end
          // rdEn was armed on entry, so it is high for exactly this cycle.
          FETCH: state <= LATCH;
          LATCH: begin
            wordBuf <= bus.sramRdData;
            byteSel <= 1'b0;
            state   <= SEND;
          end
          SEND: begin
            if (!bus.txStatus) begin
              txByte  <= pickByte(wordBuf, byteSel);
              txPulse <= 1'b1;
              state   <= WAIT_BUSY;
            end
          end
          WAIT_BUSY: begin
            if (bus.txStatus) state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (!bus.txStatus) begin
              if (inHdr) begin
                if (hdrSel) begin
                  inHdr <= 1'b0;
                  state <= FETCH;
                  rdEn  <= 1'b1;
                end else begin
                  state <= HDR1;
                end
              end else if (!byteSel) begin
                byteSel <= 1'b1;
                state   <= SEND;
              end else if (addr == LAST_ADDR) begin
                // Terminal compare precedes the increment, so addr never
                // runs past the last word.
                done  <= 1'b1;
                state <= DONE;
              end else begin
                addr  <= addr + ADDR_ONE;
                state <= FETCH;
                rdEn  <= 1'b1;
              end
            end
          end
          DONE: begin
            if (!bus.frameReady) begin
              done  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_reader.sv
module tb_pixel_reader;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frameReady = 1'b0;
  logic forceBusy = 1'b0;
  int   dlyCfg = 0;
  int   holdCfg = 5;
  logic [15:0] mem [NW];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_reader_if #(.ADDR_W(15)) b0 ();
  pixel_reader_if #(.ADDR_W(15)) b1 ();

  pixel_reader #(.WORDS(NW), .ADDR_W(15), .HEADER_EN(1'b1)) dut0 (
    .readClk(clk), .readRst(rst), .bus(b0.master));
  pixel_reader #(.WORDS(NW), .ADDR_W(15), .HEADER_EN(1'b0)) dut1 (
    .readClk(clk), .readRst(rst), .bus(b1.master));

  // SRAM models: synchronous read, data one cycle after the strobe
  logic [15:0] rd0 = '0, rd1 = '0;
  always @(posedge clk) if (b0.sramRdEn) rd0 <= mem[b0.sramAddr[1:0]];
  always @(posedge clk) if (b1.sramRdEn) rd1 <= mem[b1.sramAddr[1:0]];

  // Transmitter models: busy appears dlyCfg cycles after txStart, lasts holdCfg cycles
  int dly0 = 0, hold0 = 0, dly1 = 0, hold1 = 0;
  logic busy0 = 1'b0, busy1 = 1'b0;
  always @(posedge clk) begin
    if (hold0 > 0) begin
      hold0 <= hold0 - 1;
      if (hold0 == 1) busy0 <= 1'b0;
    end else if (dly0 > 0) begin
      dly0 <= dly0 - 1;
      if (dly0 == 1) begin busy0 <= 1'b1; hold0 <= holdCfg; end
    end else if (b0.txStart) begin
      if (dlyCfg == 0) begin busy0 <= 1'b1; hold0 <= holdCfg; end
      else dly0 <= dlyCfg;
    end
  end
  always @(posedge clk) begin
    if (hold1 > 0) begin
      hold1 <= hold1 - 1;
      if (hold1 == 1) busy1 <= 1'b0;
    end else if (dly1 > 0) begin
      dly1 <= dly1 - 1;
      if (dly1 == 1) begin busy1 <= 1'b1; hold1 <= holdCfg; end
    end else if (b1.txStart) begin
      if (dlyCfg == 0) begin busy1 <= 1'b1; hold1 <= holdCfg; end
      else dly1 <= dlyCfg;
    end
  end

  assign b0.frameReady = frameReady;
  assign b1.frameReady = frameReady;
  assign b0.sramRdData = rd0;
  assign b1.sramRdData = rd1;
  assign b0.txStatus   = busy0 | forceBusy;
  assign b1.txStatus   = busy1 | forceBusy;

  // Monitors: byte logs, protocol violations, read-strobe timing
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int st1[$];
  int rdCyc1[$];
  int rdAddr1[$];
  int viol0 = 0, viol1 = 0, dbl0 = 0, dbl1 = 0;
  logic prevRd0 = 1'b0, prevRd1 = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (b0.txStart) begin
        got0.push_back(b0.readData);
        if (b0.txStatus || dly0 > 0 || hold0 > 0) viol0 <= viol0 + 1;
      end
      if (b0.sramRdEn && prevRd0) dbl0 <= dbl0 + 1;
    end
    prevRd0 <= b0.sramRdEn;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (b1.txStart) begin
        got1.push_back(b1.readData);
        st1.push_back(cyc);
        if (b1.txStatus || dly1 > 0 || hold1 > 0) viol1 <= viol1 + 1;
      end
      if (b1.sramRdEn) begin
        rdCyc1.push_back(cyc);
        rdAddr1.push_back(int'(b1.sramAddr));
        if (prevRd1) dbl1 <= dbl1 + 1;
      end
    end
    prevRd1 <= b1.sramRdEn;
  end

  // Reference model: expected byte stream of one frame
  logic [7:0] expQ[$];
  task automatic buildExp(input bit hdr);
    expQ.delete();
    if (hdr) begin expQ.push_back(8'hAA); expQ.push_back(8'h55); end
    for (int i = 0; i < NW; i++) begin
      expQ.push_back(mem[i][7:0]);
      expQ.push_back(mem[i][15:8]);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmpStream(input string tag, input logic [7:0] g[$], input int base);
    check({tag, "_len"}, 32'(g.size() - base), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && base + i < g.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(g[base + i]), 32'(expQ[i]));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!(b0.readDone && b1.readDone) && n < 4000) begin tick(1); n++; end
    check({tag, "_done_in_time"}, 32'(n < 4000), 32'd1);
  endtask

  task automatic checkResetOuts(input string tag);
    check({tag, "_addr0"}, 32'(b0.sramAddr), 0);
    check({tag, "_rden0"}, 32'(b0.sramRdEn), 0);
    check({tag, "_data0"}, 32'(b0.readData), 0);
    check({tag, "_start0"}, 32'(b0.txStart), 0);
    check({tag, "_done0"}, 32'(b0.readDone), 0);
    check({tag, "_addr1"}, 32'(b1.sramAddr), 0);
    check({tag, "_rden1"}, 32'(b1.sramRdEn), 0);
    check({tag, "_done1"}, 32'(b1.readDone), 0);
  endtask

  task automatic randMem();
    for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
  endtask

  task automatic endFrame();
    frameReady = 1'b0;
    tick(2);
  endtask

  initial begin
    int base0, base1, s1, waitN;
    bit ok;

    // Reset state
    mem[0] = 16'h1201; mem[1] = 16'h3423; mem[2] = 16'h5645; mem[3] = 16'h7867;
    tick(3);
    checkResetOuts("reset");
    rst = 1'b0;
    tick(2);

    // Frame with header, 5-cycle busy transmitter
    frameReady = 1'b1;
    waitDone("f1");
    buildExp(1'b1); cmpStream("f1_hdr", got0, 0);
    buildExp(1'b0); cmpStream("f1_nohdr", got1, 0);
    check("f1_rdcount", 32'(rdCyc1.size()), 32'd4);
    for (int k = 0; k < NW; k++) begin
      if (k < rdAddr1.size()) check($sformatf("f1_addr%0d", k), 32'(rdAddr1[k]), 32'(k));
      if (k < rdCyc1.size() && 2 * k < st1.size())
        check($sformatf("f1_lat%0d", k), 32'(st1[2 * k] - rdCyc1[k]), 32'd3);
    end
    tick(3);
    check("f1_done_held", 32'(b0.readDone), 32'd1);
    frameReady = 1'b0;
    check("f1_done_before_edge", 32'(b0.readDone), 32'd1);
    tick(1);
    check("f1_done_drop0", 32'(b0.readDone), 32'd0);
    check("f1_done_drop1", 32'(b1.readDone), 32'd0);
    tick(2);

    // Slow transmitter: busy delayed 3 cycles, held 20
    randMem(); dlyCfg = 3; holdCfg = 20;
    base0 = got0.size(); base1 = got1.size();
    frameReady = 1'b1;
    waitDone("slow");
    buildExp(1'b1); cmpStream("slow_hdr", got0, base0);
    buildExp(1'b0); cmpStream("slow_nohdr", got1, base1);
    check("slow_viol0", 32'(viol0), 0);
    check("slow_viol1", 32'(viol1), 0);
    endFrame();

    // frameReady while transmitter busy: nothing starts until it is idle
    randMem(); dlyCfg = 0; holdCfg = 4;
    base0 = got0.size(); base1 = got1.size();
    forceBusy = 1'b1;
    frameReady = 1'b1;
    tick(12);
    check("busy_hold0", 32'(got0.size() - base0), 0);
    check("busy_hold1", 32'(got1.size() - base1), 0);
    forceBusy = 1'b0;
    waitDone("busy");
    buildExp(1'b1); cmpStream("busy_hdr", got0, base0);
    buildExp(1'b0); cmpStream("busy_nohdr", got1, base1);
    endFrame();

    // Randomized frames with random transmitter timing
    for (int it = 0; it < 3; it++) begin
      randMem();
      dlyCfg = $urandom_range(0, 4);
      holdCfg = $urandom_range(1, 8);
      base0 = got0.size(); base1 = got1.size();
      frameReady = 1'b1;
      waitDone($sformatf("rnd%0d", it));
      buildExp(1'b1); cmpStream($sformatf("rnd%0d_hdr", it), got0, base0);
      buildExp(1'b0); cmpStream($sformatf("rnd%0d_nohdr", it), got1, base1);
      endFrame();
    end
    check("rnd_viol0", 32'(viol0), 0);
    check("rnd_viol1", 32'(viol1), 0);

    // Abort after the third data byte, then restart from address 0
    randMem(); dlyCfg = 0; holdCfg = 5;
    base0 = got0.size(); base1 = got1.size();
    frameReady = 1'b1;
    waitN = 0;
    while (got0.size() < base0 + 5 && waitN < 2000) begin tick(1); waitN++; end
    check("abort_reach", 32'(waitN < 2000), 32'd1);
    frameReady = 1'b0;
    tick(2);
    s1 = got1.size();
    tick(40);
    check("abort_nomore0", 32'(got0.size() - base0), 32'd5);
    check("abort_nomore1", 32'(got1.size()), 32'(s1));
    check("abort_done0", 32'(b0.readDone), 0);
    check("abort_addr0", 32'(b0.sramAddr), 0);
    check("abort_start0", 32'(b0.txStart), 0);
    base0 = got0.size(); base1 = got1.size();
    frameReady = 1'b1;
    waitDone("restart");
    buildExp(1'b1); cmpStream("restart_hdr", got0, base0);
    buildExp(1'b0); cmpStream("restart_nohdr", got1, base1);
    endFrame();

    // Asynchronous reset during WAIT_IDLE of the second word
    randMem();
    base0 = got0.size();
    frameReady = 1'b1;
    waitN = 0;
    while (got0.size() < base0 + 5 && waitN < 2000) begin tick(1); waitN++; end
    while (!b0.txStatus && waitN < 2000) begin tick(1); waitN++; end
    check("rst_reach", 32'(waitN < 2000), 32'd1);
    tick(1);
    #2 rst = 1'b1;
    #1 checkResetOuts("midrst");
    tick(2);
    rst = 1'b0;
    base0 = got0.size(); base1 = got1.size();
    waitDone("afterrst");
    buildExp(1'b1); cmpStream("afterrst_hdr", got0, base0);
    buildExp(1'b0); cmpStream("afterrst_nohdr", got1, base1);
    s1 = got0.size();
    tick(60);
    check("nosecond0", 32'(got0.size()), 32'(s1));
    check("nosecond_done0", 32'(b0.readDone), 32'd1);
    check("nosecond_done1", 32'(b1.readDone), 32'd1);
    check("final_viol0", 32'(viol0), 0);
    check("final_viol1", 32'(viol1), 0);
    check("rden_single0", 32'(dbl0), 0);
    check("rden_single1", 32'(dbl1), 0);
    endFrame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
